// File: rtl/uart_rx_if.sv
// Serial-in / byte-out signal bundle for the UART receiver.
// The receiver uses the slave view; the line driver/consumer uses the master view.
interface uart_rx_if;
    logic       i_RX_SERIAL;
    logic       o_RX_DV;
    logic [7:0] o_RX_BYTE;
    logic       o_RX_ERR;
    logic       o_RX_ACTIVE;

    modport slave (
        input  i_RX_SERIAL,
        output o_RX_DV,
        output o_RX_BYTE,
        output o_RX_ERR,
        output o_RX_ACTIVE
    );

    modport master (
        output i_RX_SERIAL,
        input  o_RX_DV,
        input  o_RX_BYTE,
        input  o_RX_ERR,
        input  o_RX_ACTIVE
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line; mid-bit sampling after a 2-flop synchronizer.
//
// state     | meaning
// IDLE      | line idle, waiting for a low (start) level
// START_BIT | counting to mid start bit; line high there means glitch
// DATA_BITS | sampling 8 data bits, one bit period apart
// STOP_BIT  | sampling the stop bit; 1 -> byte valid, 0 -> framing error
// CLEANUP   | pulses drop; waits for the line to be high before IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     i_Clk,
    input  logic     i_Rst_n,
    uart_rx_if.slave rx
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          meta_q, sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    logic          active_q, active_d;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            meta_q   <= rx.i_RX_SERIAL;
            sync_q   <= meta_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                if (!sync_q) begin
                    state_d  = START_BIT;
                    active_d = 1'b1;
                end
            end
            START_BIT: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!sync_q) begin
                        state_d = DATA_BITS;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA_BITS: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sync_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP_BIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP_BIT: begin
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                    if (sync_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                // a line stuck low (break) must not look like a new start
                if (sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign rx.o_RX_DV     = dv_q;
    assign rx.o_RX_BYTE   = byte_q;
    assign rx.o_RX_ERR    = err_q;
    assign rx.o_RX_ACTIVE = active_q;
endmodule
